// File: rtl/carfield_apb_decode_responder.sv
// rtl/carfield_apb_decode_responder.sv - APB decoder forwarding to six peripheral targets with decode/timeout error responses
module carfield_apb_decode_responder #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AddrWidth-1:0]      paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [DataWidth-1:0]      pwdata_i,
    input  logic [DataWidth/8-1:0]    pstrb_i,
    output logic [DataWidth-1:0]      prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [5:0]                psel_o,
    output logic                      penable_o,
    output logic [AddrWidth-1:0]      paddr_o,
    output logic                      pwrite_o,
    output logic [DataWidth-1:0]      pwdata_o,
    output logic [DataWidth/8-1:0]    pstrb_o,
    input  logic [5:0][DataWidth-1:0] prdata_i,
    input  logic [5:0]                pready_i,
    input  logic [5:0]                pslverr_i,
    output logic [7:0]                err_cnt_o,
    output logic [AddrWidth-1:0]      err_addr_o,
    output logic                      err_timeout_o
);
    localparam int NumTargets = 6;
    localparam int AW1        = AddrWidth + 1;

    // Index 0 is the rightmost entry: CAN, timer, adv timer, watchdog, hyperbus cfg, streamer.
    localparam logic [NumTargets-1:0][31:0] TargetBase = {
        32'h2002_9000, 32'h2000_9000, 32'h2000_7000,
        32'h2000_5000, 32'h2000_4000, 32'h2000_1000
    };
    localparam logic [NumTargets-1:0][31:0] TargetSize = {
        32'h0000_8000, 32'h0000_1000, 32'h0000_1000,
        32'h0000_1000, 32'h0000_1000, 32'h0000_1000
    };

    // Timeout fires on the TimeoutCycles-th stalled access cycle, i.e. when
    // the number of stalls already counted is one less than the limit.
    localparam logic [7:0] LastStall = 8'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DECERR
    } state_e;

    state_e                  state_q, state_d;
    logic [NumTargets-1:0]   sel_q;
    logic [AddrWidth-1:0]    addr_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              err_cnt_q;
    logic [AddrWidth-1:0]    err_addr_q;
    logic                    err_timeout_q;

    logic [NumTargets-1:0]   hit;
    logic                    setup_accept;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DataWidth-1:0]    sel_rdata;
    logic                    err_event;
    logic                    err_is_timeout;

    always_comb begin
        hit = '0;
        for (int t = 0; t < NumTargets; t++) begin
            hit[t] = ({1'b0, paddr_i} >= AW1'(TargetBase[t])) &&
                     ({1'b0, paddr_i} <  AW1'(TargetBase[t]) + AW1'(TargetSize[t]));
        end
    end

    always_comb begin
        sel_ready = |(pready_i & sel_q);
        sel_err   = |(pslverr_i & sel_q);
        sel_rdata = '0;
        for (int t = 0; t < NumTargets; t++) begin
            sel_rdata = sel_rdata | (prdata_i[t] & {DataWidth{sel_q[t]}});
        end
    end

    assign setup_accept = (state_q == IDLE) && psel_i && !penable_i;

    assign paddr_o  = paddr_i;
    assign pwrite_o = pwrite_i;
    assign pwdata_o = pwdata_i;
    assign pstrb_o  = pstrb_i;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        psel_o         = '0;
        penable_o      = 1'b0;
        pready_o       = 1'b0;
        pslverr_o      = 1'b0;
        prdata_o       = '0;
        err_event      = 1'b0;
        err_is_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup_accept) begin
                    state_d = (|hit) ? FWD : DECERR;
                    cnt_d   = '0;
                end
            end
            FWD: begin
                if (!psel_i) begin
                    state_d = IDLE;
                end else if (penable_i) begin
                    if (!sel_ready && (cnt_q == LastStall)) begin
                        // Forced completion; the target is deselected so a
                        // late pready_i cannot complete a second time.
                        pready_o       = 1'b1;
                        pslverr_o      = 1'b1;
                        err_event      = 1'b1;
                        err_is_timeout = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        psel_o    = sel_q;
                        penable_o = 1'b1;
                        pready_o  = sel_ready;
                        pslverr_o = sel_err;
                        prdata_o  = sel_rdata;
                        if (sel_ready) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end else begin
                    psel_o = sel_q;
                end
            end
            DECERR: begin
                if (!psel_i) begin
                    state_d = IDLE;
                end else if (penable_i) begin
                    pready_o  = 1'b1;
                    pslverr_o = 1'b1;
                    err_event = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so mask responses until the state is known.
        if (!rst_ni) begin
            psel_o    = '0;
            penable_o = 1'b0;
            pready_o  = 1'b0;
            pslverr_o = 1'b0;
            prdata_o  = '0;
            err_event = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            err_cnt_q     <= '0;
            err_addr_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup_accept) begin
                addr_q <= paddr_i;
                sel_q  <= hit;
            end
            if (err_event) begin
                err_addr_q    <= addr_q;
                err_timeout_q <= err_is_timeout;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign err_cnt_o     = err_cnt_q;
    assign err_addr_o    = err_addr_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_carfield_apb_decode_responder.sv
// tb/tb_carfield_apb_decode_responder.sv - randomized self-checking bench for the APB decode responder
module tb_carfield_apb_decode_responder;
    localparam int TO = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [31:0]      paddr_i;
    logic             psel_i;
    logic             penable_i;
    logic             pwrite_i;
    logic [31:0]      pwdata_i;
    logic [3:0]       pstrb_i;
    logic [31:0]      prdata_o;
    logic             pready_o;
    logic             pslverr_o;
    logic [5:0]       psel_o;
    logic             penable_o;
    logic [31:0]      paddr_o;
    logic             pwrite_o;
    logic [31:0]      pwdata_o;
    logic [3:0]       pstrb_o;
    logic [5:0][31:0] prdata_i;
    logic [5:0]       pready_i;
    logic [5:0]       pslverr_i;
    logic [7:0]       err_cnt_o;
    logic [31:0]      err_addr_o;
    logic             err_timeout_o;

    int checks = 0;
    int failures = 0;

    int          m_err_cnt = 0;
    logic [31:0] m_err_addr = '0;
    bit          m_err_to = 1'b0;

    longint unsigned tbase[6] = '{64'h2000_1000, 64'h2000_4000, 64'h2000_5000,
                                  64'h2000_7000, 64'h2000_9000, 64'h2002_9000};
    longint unsigned tsize[6] = '{64'h1000, 64'h1000, 64'h1000, 64'h1000, 64'h1000, 64'h8000};
    logic [31:0] holes[6] = '{32'h2000_0000, 32'h2000_2000, 32'h2000_6000,
                              32'h2000_8000, 32'h2000_A000, 32'h2003_1000};

    always #5 clk_i = ~clk_i;

    carfield_apb_decode_responder #(
        .AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .paddr_i(paddr_i), .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o), .err_timeout_o(err_timeout_o)
    );

    function automatic int ref_decode(input logic [31:0] a);
        longint unsigned la = 64'(a);
        for (int t = 0; t < 6; t++)
            if (la >= tbase[t] && la < tbase[t] + tsize[t]) return t;
        return -1;
    endfunction

    task automatic drive_targets(input int tgt, input bit rdy, input bit serr, input logic [31:0] rd);
        for (int t = 0; t < 6; t++) begin
            pready_i[t]  = 1'($urandom);
            pslverr_i[t] = 1'($urandom);
            prdata_i[t]  = $urandom;
        end
        if (tgt >= 0) begin
            pready_i[tgt]  = rdy;
            pslverr_i[tgt] = serr;
            prdata_i[tgt]  = rd;
        end
    endtask

    task automatic idle_gap();
        @(negedge clk_i);
        psel_i = 1'b0;
        penable_i = 1'b0;
        drive_targets(-1, 1'b0, 1'b0, 32'h0);
    endtask

    // One full transfer: setup then access cycles until the expected completion.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                        input int wait_n, input bit serr, input logic [31:0] rd);
        int tgt, ncyc;
        bit tmo, last;
        logic [3:0]  st;
        logic [39:0] exp_v, got_v;
        tgt  = ref_decode(addr);
        tmo  = (tgt >= 0) && (wait_n >= TO);
        ncyc = (tgt < 0) ? 1 : (tmo ? TO : wait_n + 1);
        st   = 4'($urandom);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr; pwdata_i = wd; pstrb_i = st;
        drive_targets(-1, 1'b0, 1'b0, 32'h0);
        #1;
        checks++;
        if ({psel_o, penable_o, pready_o, pslverr_o, prdata_o} !== 40'h0) begin
            failures++;
            $display("FAIL setup_quiet addr=%h got psel=%b pen=%b rdy=%b err=%b rdata=%h want all 0",
                     addr, psel_o, penable_o, pready_o, pslverr_o, prdata_o);
        end
        checks++;
        if ({err_cnt_o, err_addr_o, err_timeout_o} !== {8'(m_err_cnt), m_err_addr, m_err_to}) begin
            failures++;
            $display("FAIL status got cnt=%0d addr=%h to=%b want cnt=%0d addr=%h to=%b",
                     err_cnt_o, err_addr_o, err_timeout_o, m_err_cnt, m_err_addr, m_err_to);
        end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk_i);
            penable_i = 1'b1;
            drive_targets(tgt, k >= wait_n, serr, rd);
            #1;
            last = (k == ncyc - 1);
            if (tgt < 0 || (tmo && last)) exp_v = {6'b0, 1'b1, 1'b1, 32'h0};
            else                          exp_v = {6'(1 << tgt), last, serr, rd};
            got_v = {psel_o, pready_o, pslverr_o, prdata_o};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL access addr=%h cyc=%0d got psel=%b rdy=%b err=%b rdata=%h want psel=%b rdy=%b err=%b rdata=%h",
                         addr, k, got_v[39:34], got_v[33], got_v[32], got_v[31:0],
                         exp_v[39:34], exp_v[33], exp_v[32], exp_v[31:0]);
            end
            if (tgt >= 0 && !(tmo && last)) begin
                checks++;
                if ({penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o} !== {1'b1, addr, wr, wd, st}) begin
                    failures++;
                    $display("FAIL passthru got pen=%b addr=%h wr=%b wd=%h st=%h want 1 %h %b %h %h",
                             penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o, addr, wr, wd, st);
                end
            end
        end
        if (tgt < 0 || tmo) begin
            if (m_err_cnt < 255) m_err_cnt++;
            m_err_addr = addr;
            m_err_to   = tmo;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; psel_i = 1'b1; penable_i = 1'b1; paddr_i = 32'h2000_4000;
        pwrite_i = 1'b0; pwdata_i = '0; pstrb_i = '0;
        pready_i = '1; pslverr_i = '1; prdata_i = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if ({psel_o, penable_o, pready_o, pslverr_o, prdata_o} !== 40'h0) begin
                failures++;
                $display("FAIL reset_outputs got psel=%b pen=%b rdy=%b err=%b rdata=%h want 0",
                         psel_o, penable_o, pready_o, pslverr_o, prdata_o);
            end
        end
        checks++;
        if ({err_cnt_o, err_addr_o, err_timeout_o} !== 41'h0) begin
            failures++;
            $display("FAIL reset_status got cnt=%0d addr=%h to=%b want 0", err_cnt_o, err_addr_o, err_timeout_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic test_directed();
        xfer(32'h2000_4008, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0001);
        xfer(32'h2002_F000, 1'b1, 32'h0000_1234, 3, 1'b0, 32'h0);
        xfer(32'h2000_2000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        idle_gap();
        #1;
        checks++;
        if ({err_cnt_o, err_addr_o, err_timeout_o} !== {8'd1, 32'h2000_2000, 1'b0}) begin
            failures++;
            $display("FAIL decerr_status got cnt=%0d addr=%h to=%b want 1 20002000 0",
                     err_cnt_o, err_addr_o, err_timeout_o);
        end
        xfer(32'h2000_7000, 1'b0, 32'h0, 1000, 1'b0, 32'hDEAD_BEEF);
        idle_gap();
        #1;
        checks++;
        if ({err_cnt_o, err_addr_o, err_timeout_o} !== {8'd2, 32'h2000_7000, 1'b1}) begin
            failures++;
            $display("FAIL timeout_status got cnt=%0d addr=%h to=%b want 2 20007000 1",
                     err_cnt_o, err_addr_o, err_timeout_o);
        end
        xfer(32'h2000_1004, 1'b0, 32'h0, 1, 1'b1, 32'h5555_AAAA);
        idle_gap();
        #1;
        checks++;
        if (err_cnt_o !== 8'd2) begin
            failures++;
            $display("FAIL slverr_no_status got cnt=%0d want 2", err_cnt_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int kind, wait_n;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 7);
            if (kind < 6)       a = 32'(tbase[kind] + ({32'($urandom)} % tsize[kind])) & ~32'h3;
            else if (kind == 6) a = holes[$urandom_range(0, 5)] + ($urandom % 32'h1000);
            else                a = $urandom;
            wait_n = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
            xfer(a, 1'($urandom), $urandom, wait_n, $urandom_range(0, 3) == 0, $urandom);
            if ($urandom_range(0, 1) == 1) idle_gap();
        end
    endtask

    task automatic test_protocol_drop();
        int snap;
        snap = m_err_cnt;
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h2000_5010;
        drive_targets(-1, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        penable_i = 1'b1;
        drive_targets(2, 1'b0, 1'b0, 32'h0);
        #1;
        checks++;
        if (psel_o !== 6'b000100) begin
            failures++;
            $display("FAIL drop_fwd_sel got %b want 000100", psel_o);
        end
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
        #1;
        checks++;
        if ({psel_o, penable_o, pready_o, pslverr_o} !== 9'h0) begin
            failures++;
            $display("FAIL drop_fwd_quiet got psel=%b pen=%b rdy=%b err=%b want 0",
                     psel_o, penable_o, pready_o, pslverr_o);
        end
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h2000_3000;
        @(negedge clk_i);
        psel_i = 1'b0;
        #1;
        checks++;
        if ({pready_o, pslverr_o} !== 2'b00) begin
            failures++;
            $display("FAIL drop_decerr got rdy=%b err=%b want 0 0", pready_o, pslverr_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (err_cnt_o !== 8'(snap)) begin
            failures++;
            $display("FAIL drop_status got cnt=%0d want %0d", err_cnt_o, snap);
        end
        xfer(32'h2000_9100, 1'b0, 32'h0, 2, 1'b0, 32'h0BAD_F00D);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            xfer(32'h2000_0000 + 32'((i * 4) % 4096), 1'b0, 32'h0, 0, 1'b0, 32'h0);
        end
        idle_gap();
        #1;
        checks++;
        if (err_cnt_o !== 8'd255) begin
            failures++;
            $display("FAIL saturate got cnt=%0d want 255", err_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h2000_9040;
        @(negedge clk_i);
        penable_i = 1'b1;
        drive_targets(4, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        drive_targets(4, 1'b1, 1'b1, 32'hFFFF_FFFF);
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({psel_o, penable_o, pready_o, pslverr_o, prdata_o} !== 40'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs got psel=%b pen=%b rdy=%b err=%b rdata=%h want 0",
                     psel_o, penable_o, pready_o, pslverr_o, prdata_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if ({err_cnt_o, err_addr_o, err_timeout_o, psel_o, pready_o} !== 48'h0) begin
            failures++;
            $display("FAIL reset_mid_status got cnt=%0d addr=%h to=%b psel=%b rdy=%b want 0",
                     err_cnt_o, err_addr_o, err_timeout_o, psel_o, pready_o);
        end
        rst_ni = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
        m_err_cnt = 0; m_err_addr = '0; m_err_to = 1'b0;
        xfer(32'h2000_A000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        xfer(32'h2000_1FFC, 1'b1, 32'h7777_0000, 0, 1'b0, 32'h0);
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_protocol_drop();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carfield_apb_decode_responder.md
CARFIELD_APB_DECODE_RESPONDER -- requirements
Module: carfield_apb_decode_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, APB address width.
REQ-002 SHALL have parameter DataWidth, default 32, APB data width.
REQ-003 SHALL have parameter TimeoutCycles, default 16, max access-phase cycles before forced error completion (range 1..255).
REQ-004 SHALL have a fixed 6-target map (base / size). Target 0 at 0x2000_1000 / 0x1000 (CAN). Target 1 at 0x2000_4000 / 0x1000 (timer). Target 2 at 0x2000_5000 / 0x1000 (adv timer). Target 3 at 0x2000_7000 / 0x1000 (watchdog). Target 4 at 0x2000_9000 / 0x1000 (hyperbus cfg). Target 5 at 0x2002_9000 / 0x8000 (streamer).
REQ-005 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-007 SHALL have upstream completer inputs: paddr_i (AddrWidth), psel_i (1), penable_i (1), pwrite_i (1), pwdata_i (DataWidth), pstrb_i (DataWidth/8).
REQ-008 SHALL have upstream completer outputs: prdata_o (DataWidth), pready_o (1), pslverr_o (1).
REQ-009 SHALL have downstream requester outputs: psel_o (6, one-hot), penable_o (1), paddr_o, pwrite_o, pwdata_o, pstrb_o (widths as upstream).
REQ-010 SHALL have downstream inputs: prdata_i (6 x DataWidth), pready_i (6), pslverr_i (6).
REQ-011 SHALL have status outputs: err_cnt_o (8, saturating error count), err_addr_o (AddrWidth, last failing address), err_timeout_o (1, last error was a timeout).

Function
REQ-012 SHALL decode target as base <= paddr_i < base+size; targets never overlap; no hit means unmapped.
REQ-013 SHALL implement FSM states IDLE, FWD, DECERR.
REQ-014 IDLE: on psel_i=1, penable_i=0 SHALL register the paddr_i hit index. Next state is FWD if hit, DECERR if unmapped.
REQ-015 In FWD: psel_o SHALL equal the registered one-hot index while psel_i=1; penable_o=penable_i; paddr/pwrite/pwdata/pstrb SHALL pass combinationally.
REQ-016 In FWD with penable_i=1: pready_o, pslverr_o and prdata_o SHALL mirror the selected target's inputs combinationally (zero-latency completion).
REQ-017 In FWD: when pready_o=1 and penable_i=1, SHALL return to IDLE; a back-to-back setup in the next cycle is accepted.
REQ-018 SHALL count FWD access cycles with penable_i=1 and selected pready_i=0 using an 8-bit counter cleared on entry to FWD.
REQ-019 When the counter equals TimeoutCycles, SHALL in that cycle drive pready_o=1, pslverr_o=1, prdata_o=0 and psel_o=0, then return to IDLE; a late target pready_i is ignored.
REQ-020 DECERR: SHALL keep psel_o=0. Once penable_i=1, SHALL drive pready_o=1, pslverr_o=1, prdata_o=0 in that same cycle (one access cycle), then return to IDLE.
REQ-021 Outside the responding cycles of REQ-016/019/020: pready_o=0, pslverr_o=0, prdata_o=0, psel_o=0, penable_o=0.
REQ-022 On each decode or timeout error completion, SHALL record err_addr_o with the registered address. err_timeout_o SHALL be 1 for timeout, 0 for decode error. err_cnt_o SHALL increment, saturating at 255.
REQ-023 Target pslverr_i=1 completions SHALL be forwarded only; they SHALL NOT update the error status.
REQ-024 If psel_i drops in FWD or DECERR before completion (protocol violation), SHALL return to IDLE next cycle with no status update.

Reset
REQ-025 With rst_ni=0 at a rising edge: FSM SHALL be IDLE, counter 0, err_cnt_o=0, err_addr_o=0, err_timeout_o=0.
REQ-026 During and after reset, all upstream responses and downstream psel_o/penable_o SHALL be 0. Reset mid-transfer SHALL abort the transfer with no completion.

Verification
REQ-027 Read 0x2000_4008; target 1 returns pready_i=1, prdata_i=0xCAFE_0001 in its first access cycle -> psel_o=0b000010, prdata_o=0xCAFE_0001, pready_o in that cycle, 2 cycles total.
REQ-028 Write 0x2002_F000 data 0x1234; target 5 waits 3 cycles -> psel_o=0b100000 throughout, pready_o on the 4th access cycle, pslverr_o=0.
REQ-029 Read 0x2000_2000 (unmapped) -> psel_o=0, pready_o=1 and pslverr_o=1 in the first access cycle, err_cnt_o=1, err_addr_o=0x2000_2000, err_timeout_o=0.
REQ-030 Read 0x2000_7000 with target 3 never ready, TimeoutCycles=16 -> error completion on the 16th stalled access cycle, prdata_o=0, err_timeout_o=1.
REQ-031 Issue 300 unmapped accesses -> err_cnt_o saturates at 255. Then assert rst_ni=0 mid-transfer -> all outputs 0, err_cnt_o=0.
REQ-032 Target 0 returns pslverr_i=1 -> pslverr_o=1 is forwarded, err_cnt_o unchanged.
